window_gen_kxk: RTL and testbench

//  Parametrised sliding-window generator: buffers KSIZE-1 image lines in line memories and

---
 rtl/window_gen_kxk.sv | 126 ++++++++++++
 tb/tb_window_gen_kxk.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen_kxk.sv
// Sliding KSIZE x KSIZE window generator over a raster pixel stream, using KSIZE-1 line memories.
// Latency: 1 clock from the pixel that completes a window to window_valid.
// Backpressure: none; data_enable only gates acceptance, so every valid window must be consumed.
module window_gen_kxk #(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 7,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            data_enable,
    input  logic                            sof,
    input  logic [DATA_W-1:0]               data_in,
    output logic [KSIZE*KSIZE*DATA_W-1:0]   window_out,
    output logic [DATA_W-1:0]               center_out,
    output logic                            window_valid,
    output logic [RW-1:0]                   center_row,
    output logic [CW-1:0]                   center_col,
    output logic                            frame_done
);

    localparam int HALF  = KSIZE / 2;
    localparam int ROW_W = KSIZE * DATA_W;

    localparam logic [CW-1:0] X_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] X_FIRST_WIN = CW'(KSIZE - 1);
    localparam logic [CW-1:0] X_HALF      = CW'(HALF);
    localparam logic [RW-1:0] Y_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] Y_FIRST_WIN = RW'(KSIZE - 1);
    localparam logic [RW-1:0] Y_LAST_FILL = RW'(KSIZE - 2);
    localparam logic [RW-1:0] Y_HALF      = RW'(HALF);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                         state_q;
    logic [CW-1:0]                  x_q;
    logic [RW-1:0]                  y_q;
    logic [DATA_W-1:0]              line_mem [KSIZE-1][IMG_W];
    logic [DATA_W-1:0]              col_new  [KSIZE];
    logic [KSIZE*KSIZE*DATA_W-1:0]  win_next;

    logic          restart;
    logic          accept;
    logic          eol;
    logic          last;
    logic          emit;
    logic [CW-1:0] x_cur;
    logic [RW-1:0] y_cur;

    // A start-of-frame pixel always lands at (0,0), whatever the FSM was doing.
    assign restart = data_enable && sof;
    assign accept  = data_enable && ((state_q != IDLE) || sof);
    assign x_cur   = restart ? '0 : x_q;
    assign y_cur   = restart ? '0 : y_q;
    assign eol     = (x_cur == X_LAST);
    assign last    = eol && (y_cur == Y_LAST);
    assign emit    = accept && (y_cur >= Y_FIRST_WIN) && (x_cur >= X_FIRST_WIN);

    assign center_out = window_out[(HALF*KSIZE + HALF)*DATA_W +: DATA_W];

    always_comb begin
        for (int r = 0; r < KSIZE-1; r++) begin
            col_new[r] = line_mem[r][x_cur];
        end
        col_new[KSIZE-1] = data_in;
    end

    // Each row shifts toward column 0; the new column enters at KSIZE-1.
    always_comb begin
        win_next = window_out;
        for (int r = 0; r < KSIZE; r++) begin
            win_next[r*ROW_W +: ROW_W] = {col_new[r], window_out[r*ROW_W + DATA_W +: ROW_W - DATA_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < KSIZE-2; r++) begin
                line_mem[r][x_cur] <= line_mem[r+1][x_cur];
            end
            line_mem[KSIZE-2][x_cur] <= data_in;
        end
    end

    // The window shift register doubles as the output register, so it clears with reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            center_row   <= '0;
            center_col   <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= emit;
            frame_done   <= emit && last;
            if (accept) begin
                window_out <= win_next;
                if (eol) begin
                    x_q <= '0;
                    y_q <= last ? '0 : y_cur + 1'b1;
                end else begin
                    x_q <= x_cur + 1'b1;
                    y_q <= y_cur;
                end
                if (last) begin
                    state_q <= IDLE;
                end else if (eol && (y_cur == Y_LAST_FILL)) begin
                    state_q <= RUN;
                end else if (restart) begin
                    state_q <= FILL;
                end
            end
            if (emit) begin
                center_row <= y_cur - Y_HALF;
                center_col <= x_cur - X_HALF;
            end
        end
    end

endmodule

// File: tb/tb_window_gen_kxk.sv
// Bench for window_gen_kxk: a 3x3/8x6 instance for the directed scenarios and a default-size instance with random pixels.
module tb_window_gen_kxk;

    localparam int SK = 3, SW = 8, SH = 6;
    localparam int BK = 7, BW = 64, BH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic                s_en = 1'b0, s_sof = 1'b0;
    logic [7:0]          s_din = '0;
    logic [SK*SK*8-1:0]  s_win;
    logic [7:0]          s_ctr;
    logic                s_vld, s_done;
    logic [2:0]          s_row, s_col;

    logic                b_en = 1'b0, b_sof = 1'b0;
    logic [7:0]          b_din = '0;
    logic [BK*BK*8-1:0]  b_win;
    logic [7:0]          b_ctr;
    logic                b_vld, b_done;
    logic [5:0]          b_row, b_col;

    window_gen_kxk #(.DATA_W(8), .KSIZE(SK), .IMG_W(SW), .IMG_H(SH)) u_small (
        .clk(clk), .reset(rst_n), .data_enable(s_en), .sof(s_sof), .data_in(s_din),
        .window_out(s_win), .center_out(s_ctr), .window_valid(s_vld),
        .center_row(s_row), .center_col(s_col), .frame_done(s_done)
    );

    window_gen_kxk #(.DATA_W(8), .KSIZE(BK), .IMG_W(BW), .IMG_H(BH)) u_big (
        .clk(clk), .reset(rst_n), .data_enable(b_en), .sof(b_sof), .data_in(b_din),
        .window_out(b_win), .center_out(b_ctr), .window_valid(b_vld),
        .center_row(b_row), .center_col(b_col), .frame_done(b_done)
    );

    typedef struct { logic [SK*SK*8-1:0] win; logic [7:0] ctr; int row; int col; bit done; } s_exp_t;
    typedef struct { logic [BK*BK*8-1:0] win; logic [7:0] ctr; int row; int col; bit done; } b_exp_t;
    s_exp_t s_q[$];
    b_exp_t b_q[$];

    int checks = 0;
    int errors = 0;

    int s_wins = 0, s_dones = 0, s_bad_col = 0;
    logic [SK*SK*8-1:0] s_w11, s_w21;
    logic [7:0] s_c11, s_done_ctr;
    logic [2:0] s_done_row, s_done_col;
    int b_wins = 0, b_dones = 0;
    logic [7:0] img_b [BH][BW];

    // ---------------- monitors ----------------
    task automatic mon_s();
        s_exp_t e;
        forever begin
            @(negedge clk);
            if (s_vld) begin
                s_wins++;
                if (s_row == 3'd1 && s_col == 3'd1) begin s_w11 = s_win; s_c11 = s_ctr; end
                if (s_row == 3'd2 && s_col == 3'd1) s_w21 = s_win;
                if (s_col == 3'd0 || s_col == 3'd7) s_bad_col++;
                if (s_done) begin s_dones++; s_done_ctr = s_ctr; s_done_row = s_row; s_done_col = s_col; end
                checks++;
                if (s_q.size() == 0) begin
                    errors++;
                    $display("FAIL s_unexpected_window: got row=%0d col=%0d, expected no window", s_row, s_col);
                end else begin
                    e = s_q.pop_front();
                    if (s_win !== e.win || s_ctr !== e.ctr || s_row !== 3'(e.row) ||
                        s_col !== 3'(e.col) || s_done !== e.done) begin
                        errors++;
                        $display("FAIL s_window: got r=%0d c=%0d ctr=%0d done=%0b win=%h, want r=%0d c=%0d ctr=%0d done=%0b win=%h",
                                 s_row, s_col, s_ctr, s_done, s_win, e.row, e.col, e.ctr, e.done, e.win);
                    end
                end
            end
        end
    endtask

    task automatic mon_b();
        b_exp_t e;
        forever begin
            @(negedge clk);
            if (b_vld) begin
                b_wins++;
                if (b_done) b_dones++;
                checks++;
                if (b_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_window: got row=%0d col=%0d", b_row, b_col);
                end else begin
                    e = b_q.pop_front();
                    if (b_win !== e.win || b_ctr !== e.ctr || b_row !== 6'(e.row) ||
                        b_col !== 6'(e.col) || b_done !== e.done) begin
                        errors++;
                        $display("FAIL b_window: got r=%0d c=%0d ctr=%0d done=%0b, want r=%0d c=%0d ctr=%0d done=%0b",
                                 b_row, b_col, b_ctr, b_done, e.row, e.col, e.ctr, e.done);
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic s_drive(input bit en, input bit so, input logic [7:0] d);
        @(posedge clk); #1;
        s_en = en; s_sof = so; s_din = d;
    endtask

    task automatic s_idle(input int n);
        s_drive(1'b0, 1'b0, 8'd0);
        repeat (n) @(posedge clk);
    endtask

    // Reference window for pixel (y,x) of a frame whose pixels are base+8*y+x.
    task automatic s_push(input int base, input int y, input int x);
        s_exp_t e;
        if (y >= SK-1 && x >= SK-1) begin
            for (int r = 0; r < SK; r++)
                for (int c = 0; c < SK; c++)
                    e.win[(r*SK+c)*8 +: 8] = 8'(base + 8*(y-SK+1+r) + (x-SK+1+c));
            e.ctr  = 8'(base + 8*(y-1) + (x-1));
            e.row  = y - 1;
            e.col  = x - 1;
            e.done = (y == SH-1 && x == SW-1);
            s_q.push_back(e);
        end
    endtask

    task automatic s_gap();
        logic [SK*SK*8-1:0] snap_w;
        logic [2:0] snap_r, snap_c;
        logic [7:0] snap_ctr;
        s_drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        snap_w = s_win; snap_r = s_row; snap_c = s_col; snap_ctr = s_ctr;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_win !== snap_w || s_row !== snap_r || s_col !== snap_c || s_ctr !== snap_ctr) begin
            errors++;
            $display("FAIL gap_hold: got r=%0d c=%0d win=%h, want r=%0d c=%0d win=%h", s_row, s_col, s_win, snap_r, snap_c, snap_w);
        end
        checks++;
        if (s_vld !== 1'b0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL gap_valid_low: got valid=%0b done=%0b, want 0 0", s_vld, s_done);
        end
    endtask

    // Drives a frame in raster order, stopping just before (stop_y, stop_x).
    task automatic s_frame(input int base, input bit gaps, input int stop_y, input int stop_x);
        int k;
        k = 0;
        for (int y = 0; y < SH; y++) begin
            for (int x = 0; x < SW; x++) begin
                if (y == stop_y && x == stop_x) return;
                s_push(base, y, x);
                s_drive(1'b1, (y == 0 && x == 0), 8'(base + 8*y + x));
                if (gaps && (k % 2 == 0)) s_gap();
                k++;
            end
        end
    endtask

    task automatic check_q_empty(input string name);
        checks++;
        if (s_q.size() != 0 || b_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d/%0d windows never produced, want 0", name, s_q.size(), b_q.size());
            s_q.delete();
            b_q.delete();
        end
    endtask

    task automatic check_frame_totals(input string name, input int w0, input int d0, input int want_w);
        logic [71:0] exp_first;
        exp_first = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
        checks++;
        if (s_wins - w0 != want_w) begin
            errors++;
            $display("FAIL %s_window_count: got %0d, want %0d", name, s_wins - w0, want_w);
        end
        checks++;
        if (s_dones - d0 != 1) begin
            errors++;
            $display("FAIL %s_frame_done_count: got %0d, want 1", name, s_dones - d0);
        end
        checks++;
        if (s_w11 !== exp_first || s_c11 !== 8'd9) begin
            errors++;
            $display("FAIL %s_first_window: got ctr=%0d win=%h, want ctr=9 win=%h", name, s_c11, s_w11, exp_first);
        end
        checks++;
        if (s_done_row !== 3'd4 || s_done_col !== 3'd6 || s_done_ctr !== 8'd38) begin
            errors++;
            $display("FAIL %s_frame_done_center: got (%0d,%0d) ctr=%0d, want (4,6) ctr=38",
                     name, s_done_row, s_done_col, s_done_ctr);
        end
        check_q_empty(name);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (s_win !== '0 || s_ctr !== '0 || s_vld !== 1'b0 || s_row !== '0 || s_col !== '0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_small: got win=%h ctr=%0d vld=%0b r=%0d c=%0d done=%0b, want all 0",
                     s_win, s_ctr, s_vld, s_row, s_col, s_done);
        end
        checks++;
        if (b_win !== '0 || b_ctr !== '0 || b_vld !== 1'b0 || b_row !== '0 || b_col !== '0 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_big: got ctr=%0d vld=%0b r=%0d c=%0d done=%0b, want all 0",
                     b_ctr, b_vld, b_row, b_col, b_done);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        int w0, d0;
        w0 = s_wins; d0 = s_dones;
        s_frame(0, 1'b0, SH, 0);
        s_idle(3);
        check_frame_totals("full_frame", w0, d0, 24);
    endtask

    task automatic test_enable_gaps();
        int w0, d0;
        w0 = s_wins; d0 = s_dones;
        for (int i = 0; i < 5; i++) s_drive(1'b1, 1'b0, 8'($urandom));
        s_frame(0, 1'b1, SH, 0);
        s_idle(3);
        check_frame_totals("enable_gaps", w0, d0, 24);
    endtask

    task automatic test_line_wrap();
        int bad0;
        logic [71:0] exp21;
        bad0 = s_bad_col;
        exp21 = {8'd26, 8'd25, 8'd24, 8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8};
        s_w21 = 'x;
        s_frame(0, 1'b0, SH, 0);
        s_idle(3);
        checks++;
        if (s_bad_col != bad0) begin
            errors++;
            $display("FAIL line_wrap_edge_col: got %0d windows at col 0/7, want 0", s_bad_col - bad0);
        end
        checks++;
        if (s_w21 !== exp21) begin
            errors++;
            $display("FAIL line_wrap_window_2_1: got %h, want %h", s_w21, exp21);
        end
        check_q_empty("line_wrap");
    endtask

    task automatic test_sof_abort();
        int w0, d0;
        w0 = s_wins; d0 = s_dones;
        s_frame(128, 1'b0, 3, 4);
        s_frame(0, 1'b0, SH, 0);
        s_idle(3);
        check_frame_totals("sof_abort", w0, d0, 24 + 8);
    endtask

    task automatic test_reset_mid_run();
        int w0, d0;
        s_frame(0, 1'b0, 3, 5);
        s_idle(2);
        check_q_empty("reset_mid_run_pre");
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (s_win !== '0 || s_ctr !== '0 || s_vld !== 1'b0 || s_row !== '0 || s_col !== '0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run_outputs: got win=%h ctr=%0d vld=%0b r=%0d c=%0d done=%0b, want all 0",
                     s_win, s_ctr, s_vld, s_row, s_col, s_done);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        w0 = s_wins; d0 = s_dones;
        s_drive(1'b1, 1'b0, 8'hAA);
        s_frame(0, 1'b0, SH, 0);
        s_idle(3);
        check_frame_totals("reset_mid_run", w0, d0, 24);
    endtask

    task automatic test_default_random();
        b_exp_t e;
        int w0, d0;
        w0 = b_wins; d0 = b_dones;
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                img_b[y][x] = 8'($urandom);
        for (int y = 0; y < BH; y++) begin
            for (int x = 0; x < BW; x++) begin
                if (y >= BK-1 && x >= BK-1) begin
                    for (int r = 0; r < BK; r++)
                        for (int c = 0; c < BK; c++)
                            e.win[(r*BK+c)*8 +: 8] = img_b[y-BK+1+r][x-BK+1+c];
                    e.ctr  = img_b[y-3][x-3];
                    e.row  = y - 3;
                    e.col  = x - 3;
                    e.done = (y == BH-1 && x == BW-1);
                    b_q.push_back(e);
                end
                @(posedge clk); #1;
                b_en = 1'b1; b_sof = (y == 0 && x == 0); b_din = img_b[y][x];
            end
        end
        @(posedge clk); #1;
        b_en = 1'b0; b_sof = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (b_wins - w0 != 58*58) begin
            errors++;
            $display("FAIL default_window_count: got %0d, want %0d", b_wins - w0, 58*58);
        end
        checks++;
        if (b_dones - d0 != 1) begin
            errors++;
            $display("FAIL default_frame_done_count: got %0d, want 1", b_dones - d0);
        end
        check_q_empty("default_random");
    endtask

    initial begin
        fork
            mon_s();
            mon_b();
        join_none
        test_reset();
        test_full_frame();
        test_enable_gaps();
        test_line_wrap();
        test_sof_abort();
        test_reset_mid_run();
        test_default_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
